gpgpu_obi_arbiter: RTL and testbench
====================================

# gpgpu_obi_arbiter

Two-to-one OBI arbiter that lets the instruction-side and data-side memory ports of the cached memory hierarchy share a single external OBI memory port. It sits between the instruction/data OBI master ports of the cache hierarchy and the system interconnect. It provides:
- round-robin arbitration of address phases;
- lock of the address phase until grant;
- in-order routing of responses back to the issuing side, using a small outstanding-transaction ID FIFO.

## Interface
Parameters:
- ADDR_WIDTH, 32, OBI address width
- DATA_WIDTH, 32, OBI data width; BE width is DATA_WIDTH/8
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions (power of two, ≥2)

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- s_req_i[2]  in  2  requester req; index 0 = instruction, 1 = data
- s_addr_i[2]  in  2×ADDR_WIDTH  requester address
- s_we_i[2]  in  2  write enable
- s_be_i[2]  in  2×DATA_WIDTH/8  byte enables
- s_wdata_i[2]  in  2×DATA_WIDTH  write data
- s_gnt_o[2]  out  2  grant to requester
- s_rvalid_o[2]  out  2  response valid to requester
- s_rdata_o[2]  out  2×DATA_WIDTH  response data (both driven from m_rdata_i)
- m_req_o  out  1  memory req
- m_addr_o, m_we_o, m_be_o, m_wdata_o  out  —  memory address-phase signals
- m_gnt_i  in  1  memory grant
- m_rvalid_i  in  1  memory response valid
- m_rdata_i  in  DATA_WIDTH  memory response data
- err_o  out  1  sticky protocol error (rvalid with no outstanding transaction)

## Operation
- Selection:
  - If the lock register is set, the locked source is selected.
  - Otherwise, with one requester active, that requester is selected.
  - Otherwise, with both active, the one pointed to by the priority pointer is selected.
- m_req_o = selected s_req_i AND NOT fifo_full. m_addr/we/be/wdata mux from the selected source.
- s_gnt_o[sel] = m_gnt_i AND m_req_o; the other gnt is 0.
- Handshake accepted (m_req_o & m_gnt_i):
  - push sel into the ID FIFO;
  - priority pointer ← NOT sel;
  - clear lock.
- m_req_o & !m_gnt_i: lock ← 1, locked source ← sel. The selection cannot change until grant, which keeps the OBI address phase stable.
- Response (m_rvalid_i):
  - pop the FIFO head;
  - s_rvalid_o[head] = 1 and the other is 0.
  - If the FIFO is empty, both s_rvalid_o stay 0, nothing is popped, and err_o is set (sticky until reset).
- Full FIFO (count == MAX_OUTSTANDING): m_req_o is forced 0 and no grants are given, even when m_rvalid_i pops in the same cycle. The grant reopens the following cycle.
- Simultaneous push and pop (not full): count is unchanged and ordering is preserved.
- Requesters follow OBI: req stays high until gnt. The arbiter does not check this.

## Timing
- Address-phase path s_* → m_* and m_gnt_i → s_gnt_o is combinational, with zero added latency.
- Response path m_rvalid_i/m_rdata_i → s_rvalid_o/s_rdata_o is combinational, with zero added latency.
- State (priority pointer, lock, locked source, FIFO, count, err) updates on the rising clk_i edge.
- Reset values:
  - priority pointer = 0 (instruction first);
  - lock = 0;
  - FIFO empty, count = 0;
  - err_o = 0.
- With no inputs asserted, every output is 0.
- Reset mid-transaction discards outstanding IDs. Later rvalids then flag err_o.
- FIFO pointers wrap modulo MAX_OUTSTANDING. The count width is $clog2(MAX_OUTSTANDING)+1.

## Structure
- Package gpgpu_obi_arb_pkg:
  - typedef enum logic {SRC_INSTR=1'b0, SRC_DATA=1'b1} obi_src_e;
  - constant NUM_SRC = 2.
- Sub-module gpgpu_obi_id_fifo:
  - parameter DEPTH;
  - 1-bit payload with push, pop, head, full, empty and count;
  - flop-based, asynchronous active-low reset.
- Top module contains the selection/lock logic, the muxes and err_o.

## Test plan
- Both req high from reset with m_gnt_i=1 every cycle → grants alternate instr, data, instr, data; m_addr_o follows the granted source each cycle.
- Data req alone with m_gnt_i low for 3 cycles, then instr req rises in cycle 2 → m_addr_o stays at the data address and the lock holds. Data is granted in cycle 4, then instr is granted.
- MAX_OUTSTANDING=4 and 4 grants with no rvalid → m_req_o=0 on the 5th request. An rvalid in that cycle still blocks the grant; the grant is issued the next cycle.
- Issue order instr, data, data, instr, then 4 rvalids with rdata 0xA,0xB,0xC,0xD → instr gets 0xA and 0xD, data gets 0xB and 0xC, in order.
- m_rvalid_i pulse with the FIFO empty → no s_rvalid_o, and err_o=1 stays high until rst_ni low.
- Assert rst_ni low asynchronously mid-lock with 2 outstanding → all outputs 0 immediately. After release, instr has priority, and the first rvalid sets err_o.

Source files
------------

// File: rtl/gpgpu_obi_arb_pkg.sv
// Shared types for the instruction/data OBI arbiter: requester IDs and source count.
package gpgpu_obi_arb_pkg;

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} obi_src_e;

  localparam int NUM_SRC = 2;

  function automatic obi_src_e other_src(input obi_src_e s);
    return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
  endfunction

endpackage

// File: rtl/gpgpu_obi_id_fifo.sv
// Flop-based FIFO of 1-bit requester IDs, one entry per accepted-but-unanswered OBI transaction.
module gpgpu_obi_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_din,
  input  logic                       i_pop,
  output logic                       o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rptr];

  // Guard against overflow/underflow so a misbehaving neighbour cannot corrupt the order.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/gpgpu_obi_arbiter.sv
// Two-to-one OBI arbiter: round-robin address phase with lock-until-grant, in-order response routing.
module gpgpu_obi_arbiter
  import gpgpu_obi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [NUM_SRC-1:0]                       s_req_i,
  input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]       s_addr_i,
  input  logic [NUM_SRC-1:0]                       s_we_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH/8-1:0]     s_be_i,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]       s_wdata_i,
  output logic [NUM_SRC-1:0]                       s_gnt_o,
  output logic [NUM_SRC-1:0]                       s_rvalid_o,
  output logic [NUM_SRC-1:0][DATA_WIDTH-1:0]       s_rdata_o,
  output logic                                     m_req_o,
  output logic [ADDR_WIDTH-1:0]                    m_addr_o,
  output logic                                     m_we_o,
  output logic [DATA_WIDTH/8-1:0]                  m_be_o,
  output logic [DATA_WIDTH-1:0]                    m_wdata_o,
  input  logic                                     m_gnt_i,
  input  logic                                     m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    m_rdata_i,
  output logic                                     err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  obi_src_e      r_prio;
  obi_src_e      r_lock_src;
  logic          r_lock;
  logic          r_err;

  obi_src_e      w_sel;
  logic          w_sel_idx;
  logic          w_hs;
  logic          w_rsp;
  logic          w_have_out;
  logic          w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_cnt;

  always_comb begin
    w_sel = r_prio;
    if (r_lock)                 w_sel = r_lock_src;
    else if (s_req_i == 2'b01)  w_sel = SRC_INSTR;
    else if (s_req_i == 2'b10)  w_sel = SRC_DATA;
  end

  assign w_sel_idx = w_sel;

  // rst_ni gating keeps the bus quiet the instant reset is asserted, even with requests still high.
  assign m_req_o   = s_req_i[w_sel_idx] & ~w_fifo_full & rst_ni;
  assign m_addr_o  = s_addr_i[w_sel_idx];
  assign m_we_o    = s_we_i[w_sel_idx];
  assign m_be_o    = s_be_i[w_sel_idx];
  assign m_wdata_o = s_wdata_i[w_sel_idx];
  assign w_hs      = m_req_o & m_gnt_i;

  always_comb begin
    s_gnt_o            = '0;
    s_gnt_o[w_sel_idx] = w_hs;
  end

  assign w_have_out = (w_fifo_cnt != '0);
  assign w_rsp      = m_rvalid_i & w_have_out;

  always_comb begin
    s_rvalid_o              = '0;
    s_rvalid_o[w_fifo_head] = w_rsp;
  end

  assign s_rdata_o[0] = m_rdata_i;
  assign s_rdata_o[1] = m_rdata_i;
  assign err_o        = r_err;

  gpgpu_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_hs),
    .i_din   (w_sel_idx),
    .i_pop   (w_rsp),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // An ungranted request freezes the selection so the OBI address phase stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio     <= SRC_INSTR;
      r_lock     <= 1'b0;
      r_lock_src <= SRC_INSTR;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_prio <= other_src(w_sel);
        r_lock <= 1'b0;
      end else if (m_req_o) begin
        r_lock     <= 1'b1;
        r_lock_src <= w_sel;
      end
      if (m_rvalid_i && w_fifo_empty) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpgpu_obi_arbiter.sv
// Directed bench for gpgpu_obi_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_gpgpu_obi_arbiter;

  localparam logic [31:0] IA = 32'h0000_1000;
  localparam logic [31:0] DA = 32'h0000_2000;
  localparam logic [31:0] IW = 32'h0000_0011;
  localparam logic [31:0] DW = 32'h0000_0022;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [1:0]        s_req_i = '0;
  logic [1:0][31:0]  s_addr_i;
  logic [1:0]        s_we_i;
  logic [1:0][3:0]   s_be_i;
  logic [1:0][31:0]  s_wdata_i;
  logic [1:0]        s_gnt_o;
  logic [1:0]        s_rvalid_o;
  logic [1:0][31:0]  s_rdata_o;
  logic              m_req_o;
  logic [31:0]       m_addr_o;
  logic              m_we_o;
  logic [3:0]        m_be_o;
  logic [31:0]       m_wdata_o;
  logic              m_gnt_i = 1'b0;
  logic              m_rvalid_i = 1'b0;
  logic [31:0]       m_rdata_i = '0;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  gpgpu_obi_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_i(s_req_i), .s_addr_i(s_addr_i), .s_we_i(s_we_i), .s_be_i(s_be_i), .s_wdata_i(s_wdata_i),
    .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
    .m_req_o(m_req_o), .m_addr_o(m_addr_o), .m_we_o(m_we_o), .m_be_o(m_be_o), .m_wdata_o(m_wdata_o),
    .m_gnt_i(m_gnt_i), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .err_o(err_o)
  );

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_mreq;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
    s_req_i    = req;
    m_gnt_i    = gnt;
    m_rvalid_i = rv;
    m_rdata_i  = rd;
    #1;
  endtask

  task automatic cyc(input string name, input logic [1:0] req, input logic gnt, input logic rv,
                     input logic [31:0] rd, input logic e_mreq, input logic [1:0] e_gnt, input logic [1:0] e_rv);
    drive(req, gnt, rv, rd);
    chk({name, ".m_req"}, 32'(m_req_o), 32'(e_mreq));
    chk({name, ".gnt"}, 32'(s_gnt_o), 32'(e_gnt));
    chk({name, ".rvalid"}, 32'(s_rvalid_o), 32'(e_rv));
    if (e_rv != 2'b00) chk({name, ".rdata"}, s_rdata_o[e_rv[1]], rd);
    @(negedge clk_i);
  endtask

  initial begin
    s_addr_i  = '{DA, IA};
    s_we_i    = 2'b10;
    s_be_i    = '{4'h3, 4'hF};
    s_wdata_i = '{DW, IW};

    vecs[0]  = '{2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, IA};
    vecs[1]  = '{2'b11, 1'b1, 1'b1, 32'hA, 1'b1, 2'b10, 2'b01, DA};
    vecs[2]  = '{2'b11, 1'b1, 1'b1, 32'hB, 1'b1, 2'b01, 2'b10, IA};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 32'hC, 1'b1, 2'b10, 2'b01, DA};
    vecs[4]  = '{2'b00, 1'b0, 1'b1, 32'hD, 1'b0, 2'b00, 2'b10, IA};
    vecs[5]  = '{2'b10, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, DA};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, DA};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 2'b00, DA};
    vecs[8]  = '{2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00, DA};
    vecs[9]  = '{2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00, IA};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 32'hE, 1'b0, 2'b00, 2'b10, IA};
    vecs[11] = '{2'b00, 1'b0, 1'b1, 32'hF, 1'b0, 2'b00, 2'b01, IA};

    // Reset state with every input idle.
    #2;
    chk("rst.m_req", 32'(m_req_o), 32'h0);
    chk("rst.gnt", 32'(s_gnt_o), 32'h0);
    chk("rst.rvalid", 32'(s_rvalid_o), 32'h0);
    chk("rst.err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      chk($sformatf("vec%0d.m_req", i), 32'(m_req_o), 32'(vecs[i].e_mreq));
      chk($sformatf("vec%0d.gnt", i), 32'(s_gnt_o), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d.rvalid", i), 32'(s_rvalid_o), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d.rdata", i), s_rdata_o[0] | s_rdata_o[1], vecs[i].rdata);
      chk($sformatf("vec%0d.err", i), 32'(err_o), 32'h0);
      if (vecs[i].e_mreq) begin
        chk($sformatf("vec%0d.addr", i), m_addr_o, vecs[i].e_addr);
        chk($sformatf("vec%0d.wdata", i), m_wdata_o, (vecs[i].e_addr == DA) ? DW : IW);
        chk($sformatf("vec%0d.we", i), 32'(m_we_o), (vecs[i].e_addr == DA) ? 32'h1 : 32'h0);
      end
      @(negedge clk_i);
    end

    // Fill the ID FIFO, then confirm the full block holds even across a same-cycle pop.
    for (int i = 0; i < 4; i++) cyc($sformatf("fill%0d", i), 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    cyc("full5", 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 2'b00);
    cyc("full_pop", 2'b01, 1'b1, 1'b1, 32'h5, 1'b0, 2'b00, 2'b01);
    cyc("reopen", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    for (int i = 0; i < 4; i++) cyc($sformatf("drain%0d", i), 2'b00, 1'b0, 1'b1, 32'(i), 1'b0, 2'b00, 2'b01);

    // Issue order instr, data, data, instr; responses must come back in that order.
    cyc("ord_i0", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    cyc("ord_d0", 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00);
    cyc("ord_d1", 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00);
    cyc("ord_i1", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    cyc("rsp_A", 2'b00, 1'b0, 1'b1, 32'hA, 1'b0, 2'b00, 2'b01);
    cyc("rsp_B", 2'b00, 1'b0, 1'b1, 32'hB, 1'b0, 2'b00, 2'b10);
    cyc("rsp_C", 2'b00, 1'b0, 1'b1, 32'hC, 1'b0, 2'b00, 2'b10);
    cyc("rsp_D", 2'b00, 1'b0, 1'b1, 32'hD, 1'b0, 2'b00, 2'b01);
    chk("no_err_yet", 32'(err_o), 32'h0);

    // Stray response with nothing outstanding: no rvalid routed, err sticks.
    cyc("stray", 2'b00, 1'b0, 1'b1, 32'h77, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b0, 1'b0, 32'h0);
      chk($sformatf("err_sticky%0d", i), 32'(err_o), 32'h1);
      @(negedge clk_i);
    end

    // Two outstanding (data then instr leaves priority on data), then a lock on data.
    cyc("pre_d", 2'b10, 1'b1, 1'b0, 32'h0, 1'b1, 2'b10, 2'b00);
    cyc("pre_i", 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("lock.addr", m_addr_o, DA);
    @(negedge clk_i);
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("lock2.addr", m_addr_o, DA);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst.m_req", 32'(m_req_o), 32'h0);
    chk("arst.gnt", 32'(s_gnt_o), 32'h0);
    chk("arst.rvalid", 32'(s_rvalid_o), 32'h0);
    chk("arst.err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc("post_rv", 2'b00, 1'b0, 1'b1, 32'h9, 1'b0, 2'b00, 2'b00);
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("post_err", 32'(err_o), 32'h1);
    @(negedge clk_i);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("post.addr", m_addr_o, IA);
    cyc("post_prio", 2'b11, 1'b1, 1'b0, 32'h0, 1'b1, 2'b01, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
